// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, frame FSM and an output
// register with valid/ready handshake and framing/parity/overrun flags.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   output logic [DATA_BITS-1:0] dout,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);

   // ds fell one cycle before IDLE reacts, so the half-bit wait ends one early
   localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 2);
   localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t               state;
   logic                 meta;
   logic                 ds;
   logic [CW-1:0]        ccnt;
   logic [BW-1:0]        bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 ferr;
   logic                 perr;
   logic                 done;

   // two-flop synchroniser, reset high so the line looks idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b1;
         ds   <= 1'b1;
      end else begin
         meta <= din;
         ds   <= meta;
      end
   end

   // frame state machine: start check, data shift, parity, stop bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         ccnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
         ferr  <= 1'b0;
         perr  <= 1'b0;
         done  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!ds) begin
                  state <= S_START;
                  ccnt  <= '0;
                  busy  <= 1'b1;
               end
            end
            S_START: begin
               if (ccnt == HALF_END) begin
                  ccnt <= '0;
                  bcnt <= '0;
                  if (ds) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_DATA;
                  end
               end else begin
                  ccnt <= ccnt + 1'b1;
               end
            end
            S_DATA: begin
               if (ccnt == BIT_END) begin
                  ccnt  <= '0;
                  shreg <= {ds, shreg[DATA_BITS-1:1]};
                  if (bcnt == LAST_DATA) begin
                     bcnt  <= '0;
                     ferr  <= 1'b0;
                     perr  <= 1'b0;
                     state <= PARITY_EN ? S_PARITY : S_STOP;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end else begin
                  ccnt <= ccnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (ccnt == BIT_END) begin
                  ccnt  <= '0;
                  perr  <= ^shreg ^ ds ^ PARITY_ODD;
                  state <= S_STOP;
               end else begin
                  ccnt <= ccnt + 1'b1;
               end
            end
            S_STOP: begin
               if (ccnt == BIT_END) begin
                  ccnt <= '0;
                  ferr <= ferr | ~ds;
                  if (bcnt == LAST_STOP) begin
                     bcnt  <= '0;
                     done  <= 1'b1;
                     state <= ds ? S_IDLE : S_WAIT_HIGH;
                     busy  <= ~ds;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end else begin
                  ccnt <= ccnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (ds) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // output word register: load, hold under backpressure, flag overruns
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout        <= '0;
         dout_valid  <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (done && (!dout_valid || dout_ready)) begin
            dout       <= shreg;
            frame_err  <= ferr;
            parity_err <= perr;
            dout_valid <= 1'b1;
         end else if (done) begin
            overrun_err <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations, directed and random
// frames, checked against expectations derived from the frame contents.
module tb_uart_rx_param;

   localparam int CPB = 16;

   typedef struct {
      logic [8:0] d;
      logic       fe;
      logic       pe;
      int         t;
   } rec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   nassert = 0;
   int   nfail = 0;
   int   t_start = 0;

   logic       din_a, rdy_a, v_a, fe_a, pe_a, ov_a, busy_a;
   logic [7:0] dout_a;
   logic       din_p, rdy_p, v_p, fe_p, pe_p, ov_p, busy_p;
   logic [7:0] dout_p;
   logic       din_c, rdy_c, v_c, fe_c, pe_c, ov_c, busy_c;
   logic [6:0] dout_c;

   rec_t rq_a[$];
   rec_t rq_p[$];
   rec_t rq_c[$];
   int   vcnt_a = 0;
   int   ocnt_a = 0;
   int   ocnt_p = 0;
   int   ocnt_c = 0;
   int   rise_a = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b0),
      .PARITY_ODD(1'b0), .STOP_BITS(1)
   ) u_a (
      .clk(clk), .rst(rst), .din(din_a), .dout(dout_a),
      .dout_valid(v_a), .dout_ready(rdy_a), .frame_err(fe_a),
      .parity_err(pe_a), .overrun_err(ov_a), .busy(busy_a)
   );

   uart_rx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b1),
      .PARITY_ODD(1'b0), .STOP_BITS(1)
   ) u_p (
      .clk(clk), .rst(rst), .din(din_p), .dout(dout_p),
      .dout_valid(v_p), .dout_ready(rdy_p), .frame_err(fe_p),
      .parity_err(pe_p), .overrun_err(ov_p), .busy(busy_p)
   );

   uart_rx_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1'b0),
      .PARITY_ODD(1'b0), .STOP_BITS(2)
   ) u_c (
      .clk(clk), .rst(rst), .din(din_c), .dout(dout_c),
      .dout_valid(v_c), .dout_ready(rdy_c), .frame_err(fe_c),
      .parity_err(pe_c), .overrun_err(ov_c), .busy(busy_c)
   );

   // capture every accepted word, valid rise times and overrun pulses
   initial begin
      rec_t r;
      logic va_q;
      va_q = 1'b0;
      forever begin
         @(negedge clk);
         if (v_a && !va_q) rise_a = cyc;
         va_q = v_a;
         if (v_a) vcnt_a++;
         if (ov_a) ocnt_a++;
         if (ov_p) ocnt_p++;
         if (ov_c) ocnt_c++;
         if (v_a && rdy_a) begin
            r.d = {1'b0, dout_a}; r.fe = fe_a; r.pe = pe_a; r.t = rise_a;
            rq_a.push_back(r);
         end
         if (v_p && rdy_p) begin
            r.d = {1'b0, dout_p}; r.fe = fe_p; r.pe = pe_p; r.t = cyc;
            rq_p.push_back(r);
         end
         if (v_c && rdy_c) begin
            r.d = {2'b0, dout_c}; r.fe = fe_c; r.pe = pe_c; r.t = cyc;
            rq_c.push_back(r);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_perr(input logic [8:0] d, input int nbits,
                                     input logic pbit, input bit odd);
      int ones;
      ones = int'(pbit) + int'(odd);
      for (int i = 0; i < nbits; i++) ones += int'(d[i]);
      return (ones % 2) != 0;
   endfunction

   function automatic int qsize(input int w);
      if (w == 0) return rq_a.size();
      if (w == 1) return rq_p.size();
      return rq_c.size();
   endfunction

   task automatic set_din(input int w, input logic v);
      case (w)
         0: din_a = v;
         1: din_p = v;
         default: din_c = v;
      endcase
   endtask

   task automatic bit_wait();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send(input int w, input logic [8:0] data, input int nbits,
                       input bit par, input logic pbit, input int nstop,
                       input logic stopv);
      @(posedge clk);
      #1;
      t_start = cyc;
      set_din(w, 1'b0);
      bit_wait();
      for (int i = 0; i < nbits; i++) begin
         set_din(w, data[i]);
         bit_wait();
      end
      if (par) begin
         set_din(w, pbit);
         bit_wait();
      end
      for (int i = 0; i < nstop; i++) begin
         set_din(w, stopv);
         bit_wait();
      end
   endtask

   task automatic expect_word(input int w, input string tag,
                              input logic [8:0] d, input logic fe,
                              input logic pe, output rec_t r);
      chk({tag, "_present"}, 32'(qsize(w) > 0), 32'd1);
      r.d = '0; r.fe = 1'b0; r.pe = 1'b0; r.t = 0;
      if (qsize(w) > 0) begin
         case (w)
            0: r = rq_a.pop_front();
            1: r = rq_p.pop_front();
            default: r = rq_c.pop_front();
         endcase
         chk({tag, "_dout"}, 32'(r.d), 32'(d));
         chk({tag, "_frame_err"}, 32'(r.fe), 32'(fe));
         chk({tag, "_parity_err"}, 32'(r.pe), 32'(pe));
      end
   endtask

   initial begin
      rec_t       r;
      int         t0, v0, o0, n;
      logic       seen, sv, pb;
      logic [8:0] d;

      rst = 1'b0;
      din_a = 1'b1; din_p = 1'b1; din_c = 1'b1;
      rdy_a = 1'b1; rdy_p = 1'b1; rdy_c = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout_a", 32'(dout_a), 32'd0);
      chk("rst_valid_a", 32'(v_a), 32'd0);
      chk("rst_flags_a", 32'({fe_a, pe_a, ov_a}), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_all_p", 32'({dout_p, v_p, fe_p, pe_p, ov_p, busy_p}), 32'd0);
      chk("rst_all_c", 32'({dout_c, v_c, fe_c, pe_c, ov_c, busy_c}), 32'd0);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // basic frame, latency and single-cycle valid
      v0 = vcnt_a;
      send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      t0 = t_start;
      repeat (8) @(posedge clk);
      #1;
      chk("t1_count", 32'(rq_a.size()), 32'd1);
      expect_word(0, "t1", 9'h0A5, 1'b0, 1'b0, r);
      chk("t1_latency", 32'(r.t - t0), 32'd155);
      chk("t1_valid_cycles", 32'(vcnt_a - v0), 32'd1);
      chk("t1_valid_low", 32'(v_a), 32'd0);

      // start-bit glitch
      v0 = vcnt_a;
      @(posedge clk);
      #1;
      din_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      din_a = 1'b1;
      seen = busy_a;
      n = 0;
      while (busy_a && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t2_busy_seen", 32'(seen), 32'd1);
      chk("t2_busy_clear", 32'(busy_a), 32'd0);
      chk("t2_busy_within_9", 32'(n <= 9), 32'd1);
      repeat (12 * CPB) @(posedge clk);
      #1;
      chk("t2_no_word", 32'(rq_a.size()), 32'd0);
      chk("t2_no_valid", 32'(vcnt_a - v0), 32'd0);

      // even parity: wrong then right parity bit
      send(1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      chk("t3_count_bad", 32'(rq_p.size()), 32'd1);
      expect_word(1, "t3_bad", 9'h03C, 1'b0,
                  exp_perr(9'h03C, 8, 1'b1, 1'b0), r);
      send(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      chk("t3_count_good", 32'(rq_p.size()), 32'd1);
      expect_word(1, "t3_good", 9'h03C, 1'b0,
                  exp_perr(9'h03C, 8, 1'b0, 1'b0), r);

      // low stop bit then a held-low line
      send(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
      repeat (40 * CPB) @(posedge clk);
      #1;
      chk("t4_busy_held", 32'(busy_a), 32'd1);
      chk("t4_count", 32'(rq_a.size()), 32'd1);
      expect_word(0, "t4", 9'h055, 1'b1, 1'b0, r);
      din_a = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      chk("t4_busy_released", 32'(busy_a), 32'd0);
      chk("t4_no_extra", 32'(rq_a.size()), 32'd0);
      send(0, 9'h066, 8, 1'b0, 1'b0, 1, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      expect_word(0, "t4_next", 9'h066, 1'b0, 1'b0, r);

      // overrun under backpressure, then accept
      rdy_a = 1'b0;
      o0 = ocnt_a;
      send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
      send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_dout_held", 32'(dout_a), 32'h11);
      chk("t5_valid_held", 32'(v_a), 32'd1);
      chk("t5_overrun_pulses", 32'(ocnt_a - o0), 32'd1);
      chk("t5_none_taken", 32'(rq_a.size()), 32'd0);
      @(posedge clk);
      #1;
      rdy_a = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_valid_drop", 32'(v_a), 32'd0);
      chk("t5_count", 32'(rq_a.size()), 32'd1);
      expect_word(0, "t5", 9'h011, 1'b0, 1'b0, r);

      // accept on the same cycle a new word arrives
      rdy_a = 1'b0;
      o0 = ocnt_a;
      send(0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1);
      t_start = -1;
      fork
         send(0, 9'h044, 8, 1'b0, 1'b0, 1, 1'b1);
         begin
            wait (t_start >= 0);
            wait (cyc == t_start + 154);
            #1;
            rdy_a = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("t6_no_overrun", 32'(ocnt_a - o0), 32'd0);
      chk("t6_count", 32'(rq_a.size()), 32'd2);
      expect_word(0, "t6_old", 9'h033, 1'b0, 1'b0, r);
      expect_word(0, "t6_new", 9'h044, 1'b0, 1'b0, r);

      // random frames on the plain and parity receivers
      for (int k = 0; k < 8; k++) begin
         d = 9'($urandom_range(0, 255));
         sv = ($urandom_range(0, 3) != 0);
         send(0, d, 8, 1'b0, 1'b0, 1, sv);
         repeat (8) @(posedge clk);
         #1;
         chk("rnd_a_count", 32'(rq_a.size()), 32'd1);
         expect_word(0, "rnd_a", d, ~sv, 1'b0, r);
         din_a = 1'b1;
         repeat ($urandom_range(2, CPB)) @(posedge clk);

         d = 9'($urandom_range(0, 255));
         sv = ($urandom_range(0, 3) != 0);
         pb = 1'($urandom_range(0, 1));
         send(1, d, 8, 1'b1, pb, 1, sv);
         repeat (8) @(posedge clk);
         #1;
         chk("rnd_p_count", 32'(rq_p.size()), 32'd1);
         expect_word(1, "rnd_p", d, ~sv, exp_perr(d, 8, pb, 1'b0), r);
         din_p = 1'b1;
         repeat ($urandom_range(2, CPB)) @(posedge clk);
      end
      chk("rnd_overruns", 32'(ocnt_a + ocnt_p - o0), 32'd0);

      // 7-bit / 2-stop: held errored word, reset mid-frame, fresh frame
      rdy_c = 1'b0;
      send(2, 9'h02A, 7, 1'b0, 1'b0, 2, 1'b0);
      din_c = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      chk("t8_held_dout", 32'(dout_c), 32'h2A);
      chk("t8_held_flags", 32'({v_c, fe_c}), 32'd3);
      din_c = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      #1;
      chk("t8_busy_mid", 32'(busy_c), 32'd1);
      rst = 1'b0;
      #2;
      chk("t8_rst_dout", 32'(dout_c), 32'd0);
      chk("t8_rst_flags", 32'({v_c, fe_c, pe_c, ov_c, busy_c}), 32'd0);
      din_c = 1'b1;
      rdy_c = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      #1;
      chk("t8_idle_after", 32'(busy_c), 32'd0);
      chk("t8_no_word", 32'(rq_c.size()), 32'd0);
      send(2, 9'h04B, 7, 1'b0, 1'b0, 2, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      chk("t8_count", 32'(rq_c.size()), 32'd1);
      expect_word(2, "t8", 9'h04B, 1'b0, 1'b0, r);
      chk("t8_no_overrun", 32'(ocnt_c), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nassert, nfail);
      $finish;
   end

endmodule
